// File: rtl/sng_pkg.sv
// sng_pkg
//   Shared definitions for the stochastic number generator slice:
//   - sng_state_t      : stream controller state encoding
//   - SNG_DEFAULT_TAPS : maximal-length Fibonacci taps for an 8-bit LFSR
//   - SNG_MAX_W        : widest LFSR the rotl helper can handle
//   - rotl()           : rotate-left of the low 'width' bits of a value
package sng_pkg;

  typedef enum logic [1:0] {
    SNG_IDLE = 2'd0,
    SNG_RUN  = 2'd1,
    SNG_DONE = 2'd2
  } sng_state_t;

  localparam logic [7:0] SNG_DEFAULT_TAPS = 8'hB8;
  localparam int         SNG_MAX_W        = 32;

  // Bits at and above 'width' are ignored and returned as zero.
  // A shift amount that is a multiple of 'width' returns the value
  // unchanged; that case is split out because the right shift would
  // otherwise be by the full width.
  function automatic logic [SNG_MAX_W-1:0] rotl(
    input logic [SNG_MAX_W-1:0] value,
    input int                   amount,
    input int                   width = 8
  );
    logic [SNG_MAX_W-1:0] mask;
    logic [SNG_MAX_W-1:0] res;
    int                   a;
    a    = amount % width;
    mask = (width >= SNG_MAX_W) ? '1
                                : ((SNG_MAX_W'(1) << width) - SNG_MAX_W'(1));
    if (a == 0) begin
      res = value & mask;
    end else begin
      res = (((value & mask) << a) | ((value & mask) >> (width - a))) & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr_zi.sv
// lfsr_zi
//   Zero-inserted (de Bruijn) Fibonacci LFSR. The all-zero state is spliced
//   into the normal maximal-length sequence, so the period is exactly
//   2^WIDTH and every WIDTH-bit value appears once per period.
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset (state <= START_STATE)
//   load   in  1      reload START_STATE (has priority over en)
//   en     in  1      advance one step
//   state  out WIDTH  current LFSR value
module lfsr_zi
  import sng_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAP_MASK    = SNG_DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] START_STATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  logic feedback;

  // The extra XOR flips the feedback when the low WIDTH-1 bits are zero:
  // 10..0 goes to 00..0 instead of 00..01, and 00..0 then goes to 00..01.
  assign feedback = (^(state & TAP_MASK)) ^ (state[WIDTH-2:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START_STATE;
    end else if (load) begin
      state <= START_STATE;
    end else if (en) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/lfsr_sng_multi.sv
// lfsr_sng_multi
//   Multi-channel stochastic number generator. Every channel compares its
//   latched binary input against its own view of one shared zero-inserted
//   LFSR. In correlated mode all channels see the raw LFSR value. In
//   decorrelated mode channel i sees that value rotated left by
//   (i*ROT_STEP) mod WIDTH. A stream runs for a latched length, where 0 or
//   anything above 2^WIDTH means 2^WIDTH, and ends with a one-cycle done
//   pulse.
//
// Optional feature macro: SNG_ET_EN (early termination via et_stop, plus
//   et_flag and per-channel ones counters).
//
// Ports:
//   clk        in  1                        clock, rising edge
//   rst_n      in  1                        asynchronous active-low reset
//   start      in  1                        begin a stream (used only in IDLE)
//   corr_mode  in  1                        1 = shared value, 0 = rotated views
//   len        in  WIDTH+1                  stream length, 0 = 2^WIDTH
//   Bxs        in  NUM_INPUTS*WIDTH         channel i at [i*WIDTH +: WIDTH]
//   Xs         out NUM_INPUTS               stochastic bits, zero unless valid
//   valid      out 1                        Xs meaningful this cycle
//   busy       out 1                        controller not IDLE
//   done       out 1                        one-cycle pulse after last bit
//   cnt        out WIDTH+1                  bits emitted in current stream
//   et_stop    in  1                        (SNG_ET_EN) make this bit the last
//   et_flag    out 1                        (SNG_ET_EN) stream ended early
//   ones_cnt   out NUM_INPUTS*(WIDTH+1)     (SNG_ET_EN) per-channel ones
module lfsr_sng_multi
  import sng_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_INPUTS  = 2,
  parameter logic [WIDTH-1:0] START_STATE = 1,
  parameter logic [WIDTH-1:0] TAP_MASK    = SNG_DEFAULT_TAPS,
  parameter int               ROT_STEP    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          corr_mode,
  input  logic [WIDTH:0]                len,
  input  logic [NUM_INPUTS*WIDTH-1:0]   Bxs,
`ifdef SNG_ET_EN
  input  logic                          et_stop,
  output logic                          et_flag,
  output logic [NUM_INPUTS*(WIDTH+1)-1:0] ones_cnt,
`endif
  output logic [NUM_INPUTS-1:0]         Xs,
  output logic                          valid,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH:0]                cnt
);

  localparam logic [WIDTH:0] FULL_LEN = {1'b1, {WIDTH{1'b0}}};

  sng_state_t                  state;
  logic [WIDTH-1:0]            lfsr_state;
  logic [NUM_INPUTS*WIDTH-1:0] bx_lat;
  logic                        corr_lat;
  logic [WIDTH:0]              len_lat;
  logic [WIDTH:0]              len_in_eff;
  logic                        accept;
  logic                        last_bit;
  logic [WIDTH-1:0]            r_view [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]       cmp;

`ifdef SNG_ET_EN
  logic [WIDTH:0] ones_q [NUM_INPUTS];
  logic           et_flag_q;
`endif

  assign accept     = (state == SNG_IDLE) && start;
  assign len_in_eff = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;

  // cnt equals the index of the bit currently on Xs while in RUN.
`ifdef SNG_ET_EN
  assign last_bit = (cnt == (len_lat - 1'b1)) || et_stop;
`else
  assign last_bit = (cnt == (len_lat - 1'b1));
`endif

  lfsr_zi #(
    .WIDTH       (WIDTH),
    .TAP_MASK    (TAP_MASK),
    .START_STATE (START_STATE)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (state == SNG_RUN),
    .state (lfsr_state)
  );

  // Channel 0 has zero rotation, so it matches the raw LFSR in both modes.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      r_view[i] = corr_lat ? lfsr_state
                           : WIDTH'(rotl(SNG_MAX_W'(lfsr_state),
                                         (i * ROT_STEP) % WIDTH, WIDTH));
      cmp[i] = bx_lat[i*WIDTH +: WIDTH] > r_view[i];
    end
  end

  assign Xs = valid ? cmp : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SNG_IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bx_lat   <= '0;
      corr_lat <= 1'b0;
      len_lat  <= FULL_LEN;
    end else begin
      case (state)
        SNG_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SNG_RUN;
            valid    <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            bx_lat   <= Bxs;
            corr_lat <= corr_mode;
            len_lat  <= len_in_eff;
          end
        end
        SNG_RUN: begin
          if (cnt < len_lat) begin
            cnt <= cnt + 1'b1;
          end
          if (last_bit) begin
            state <= SNG_DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end
        SNG_DONE: begin
          state <= SNG_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= SNG_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SNG_ET_EN
  // Ones counters track what Xs emits. They are cleared on start and held
  // afterwards. et_flag is raised together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      et_flag_q <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        ones_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        et_flag_q <= 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          ones_q[i] <= '0;
        end
      end else if (state == SNG_RUN) begin
        et_flag_q <= last_bit && et_stop;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          ones_q[i] <= ones_q[i] + (WIDTH+1)'(cmp[i]);
        end
      end else begin
        et_flag_q <= 1'b0;
      end
    end
  end

  assign et_flag = et_flag_q;

  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ones_cnt[i*(WIDTH+1) +: (WIDTH+1)] = ones_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_sng_multi.sv
// tb_lfsr_sng_multi
//   Directed bench for lfsr_sng_multi. A table of whole-stream vectors
//   gives the expected ones counts, AND/XOR statistics and stream lengths.
//   Hand-written sequences cover reset values, the idle Xs gating,
//   mid-stream reset with replay, and early termination when SNG_ET_EN is
//   defined.
module tb_lfsr_sng_multi;

  localparam int WIDTH      = 8;
  localparam int NUM_INPUTS = 2;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic                        corr_mode = 1'b0;
  logic [WIDTH:0]              len = '0;
  logic [NUM_INPUTS*WIDTH-1:0] Bxs = '0;
  logic [NUM_INPUTS-1:0]       Xs;
  logic                        valid;
  logic                        busy;
  logic                        done;
  logic [WIDTH:0]              cnt;
`ifdef SNG_ET_EN
  logic                           et_stop = 1'b0;
  logic                           et_flag;
  logic [NUM_INPUTS*(WIDTH+1)-1:0] ones_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] bx0;
    logic [7:0] bx1;
    logic       corr;
    logic [8:0] len;
    int         eff_len;
    int         ones0;
    int         ones1;
    int         and_ones;
    int         diffs;
    bit         chk_bits;
  } vec_t;

  // First 16 LFSR states from START_STATE=1 with taps 0xB8, worked by hand.
  logic [7:0] lfsr_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23,
                                8'h47, 8'h8E, 8'h1C, 8'h38, 8'h71, 8'hE2,
                                8'hC4, 8'h89, 8'h12, 8'h25};

  vec_t vecs [8];
  vec_t replay_vec;
  vec_t et_vec;

  always #5 clk = ~clk;

  lfsr_sng_multi #(
    .WIDTH       (WIDTH),
    .NUM_INPUTS  (NUM_INPUTS),
    .START_STATE (8'h01),
    .TAP_MASK    (8'hB8),
    .ROT_STEP    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .corr_mode (corr_mode),
    .len       (len),
    .Bxs       (Bxs),
`ifdef SNG_ET_EN
    .et_stop   (et_stop),
    .et_flag   (et_flag),
    .ones_cnt  (ones_cnt),
`endif
    .Xs        (Xs),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .cnt       (cnt)
  );

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  // Presents a vector and pulses start. Returns at the negedge inside the
  // first bit cycle. The inputs are then scrambled to prove they were latched.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    Bxs       = {v.bx1, v.bx0};
    corr_mode = v.corr;
    len       = v.len;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    Bxs       = ~{v.bx1, v.bx0};
    corr_mode = ~v.corr;
    len       = 9'd5;
  endtask

  // Runs one stream. glitch_at and et_at are cycle numbers after the start
  // edge, or -1 for none.
  task automatic runStream(input vec_t v, input int glitch_at, input int et_at, input string tag);
    int ones0, ones1, and_ones, diffs, k, done_cycle, cnt_at_done, exp_len;
`ifdef SNG_ET_EN
    int et_at_done, oc0, oc1;
    et_at_done = 0;
    oc0 = 0;
    oc1 = 0;
`endif
    ones0 = 0; ones1 = 0; and_ones = 0; diffs = 0; k = 0;
    done_cycle = -1; cnt_at_done = -1;
    exp_len = (et_at > 0) ? et_at : v.eff_len;
    applyStimulus(v);
    for (int c = 1; c <= v.eff_len + 4; c++) begin
      if (done) begin
        done_cycle  = c;
        cnt_at_done = int'(cnt);
`ifdef SNG_ET_EN
        et_at_done = int'(et_flag);
        oc0 = int'(ones_cnt[0 +: WIDTH+1]);
        oc1 = int'(ones_cnt[WIDTH+1 +: WIDTH+1]);
`endif
        break;
      end
      if (valid) begin
        ones0    += int'(Xs[0]);
        ones1    += int'(Xs[1]);
        and_ones += int'(Xs[0] & Xs[1]);
        diffs    += int'(Xs[0] ^ Xs[1]);
        if (v.chk_bits && k < 16 && k < v.eff_len) begin
          checkOutput($sformatf("%s bit%0d", tag, k), int'(Xs[0]),
                      int'(v.bx0 > lfsr_seq[k]));
        end
        k++;
      end
      start = (c == glitch_at);
`ifdef SNG_ET_EN
      et_stop = (c == et_at);
`endif
      @(negedge clk);
    end
    start = 1'b0;
`ifdef SNG_ET_EN
    et_stop = 1'b0;
`endif
    checkOutput({tag, " done_cycle"}, done_cycle, exp_len + 1);
    checkOutput({tag, " valid_cycles"}, k, exp_len);
    checkOutput({tag, " cnt_at_done"}, cnt_at_done, exp_len);
    checkOutput({tag, " ones0"}, ones0, v.ones0);
    checkOutput({tag, " ones1"}, ones1, v.ones1);
    checkOutput({tag, " and_ones"}, and_ones, v.and_ones);
    checkOutput({tag, " diffs"}, diffs, v.diffs);
`ifdef SNG_ET_EN
    checkOutput({tag, " et_flag"}, et_at_done, int'(et_at > 0));
    checkOutput({tag, " ones_cnt0"}, oc0, v.ones0);
    checkOutput({tag, " ones_cnt1"}, oc1, v.ones1);
`endif
    @(negedge clk);
    checkOutput({tag, " done_pulse_width"}, int'(done), 0);
    checkOutput({tag, " busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int done_seen;
    //              bx0    bx1    corr  len     eff  o0   o1   and  diff chk
    vecs[0] = '{8'hC0, 8'h80, 1'b1, 9'h000, 256, 192, 128, 128,  64, 1'b0};
    vecs[1] = '{8'hC0, 8'h80, 1'b0, 9'h100, 256, 192, 128,  96, 128, 1'b0};
    vecs[2] = '{8'h03, 8'h03, 1'b1, 9'h000, 256,   3,   3,   3,   0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 9'd16,   16,  16,  16,  16,   0, 1'b0};
    vecs[4] = '{8'h55, 8'h00, 1'b1, 9'h1FF, 256,  85,   0,   0,  85, 1'b0};
    vecs[5] = '{8'h05, 8'h03, 1'b1, 9'd4,     4,   3,   2,   2,   1, 1'b1};
    vecs[6] = '{8'h02, 8'h01, 1'b0, 9'd1,     1,   1,   0,   0,   1, 1'b1};
    vecs[7] = '{8'h20, 8'h20, 1'b0, 9'd16,   16,   7,   3,   2,   6, 1'b1};
    replay_vec = '{8'h80, 8'h00, 1'b1, 9'd16, 16, 12, 0, 0, 12, 1'b1};
    et_vec     = '{8'h80, 8'h20, 1'b1, 9'h000, 256, 9, 6, 6, 3, 1'b0};

    // Reset values, with Bxs high so an ungated comparator would show.
    Bxs = '1;
    #3;
    checkOutput("reset Xs", int'(Xs), 0);
    checkOutput("reset valid", int'(valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset cnt", int'(cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle Xs gated", int'(Xs), 0);

    // The start pulse in vector 3 lands during RUN and must be ignored.
    for (int i = 0; i < 8; i++) begin
      runStream(vecs[i], (i == 3) ? 5 : -1, -1, $sformatf("vec%0d", i));
    end

    // Abort a full-length stream at bit 100 with an asynchronous reset.
    applyStimulus(vecs[0]);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
    end
    checkOutput("abort valid_before", int'(valid), 1);
    checkOutput("abort cnt_before", int'(cnt), 100);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort Xs", int'(Xs), 0);
    checkOutput("abort valid", int'(valid), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort cnt", int'(cnt), 0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    checkOutput("abort no_done", done_seen, 0);
    runStream(replay_vec, -1, -1, "replay");

`ifdef SNG_ET_EN
    // et_stop during bit 9 (cycle 10) makes that bit the last one.
    runStream(et_vec, -1, 10, "et");
    @(negedge clk);
    et_stop = 1'b1;
    @(negedge clk);
    checkOutput("et idle_no_effect", int'(busy), 0);
    et_stop = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
